// File: rtl/param_serializer.sv
// Parallel-to-serial shifter for the UART TX path with a one-entry holding buffer,
// configurable width, bit order and optional parity bit.
module param_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PAR_EN     = 0,
    parameter int PAR_ODD    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_busy,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  ser_data_q, ser_data_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            ser_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            ser_data_q  <= ser_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        ser_data_d  = ser_data_q;

        // Intake only fills an empty buffer, so it can never collide with the IDLE drain below.
        if (in_valid && !hold_full_q) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_data_q;
                    par_d       = (^hold_data_q) ^ (PAR_ODD != 0);
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (MSB_FIRST != 0) begin
                        ser_data_d = shift_q[DATA_WIDTH-1];
                        shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        ser_data_d = shift_q[0];
                        shift_d    = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = (PAR_EN != 0) ? PARITY : DONE;
                    end
                end
            end
            PARITY: begin
                if (ser_en) begin
                    ser_data_d = par_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = !hold_full_q;
    assign ser_data = ser_data_q;
    assign ser_busy = (state_q != IDLE);
    assign ser_done = (state_q == DONE);

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: four 8-bit instances (LSB-first, MSB-first,
// even parity, odd parity) share one stimulus stream.
module tb_param_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] inData;
    logic       inValid;
    logic       serEn;
    logic [3:0] inReady;
    logic [3:0] serData;
    logic [3:0] serBusy;
    logic [3:0] serDone;

    int compareCount  = 0;
    int mismatchCount = 0;

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_EN(0), .PAR_ODD(0)) dutLsb (
        .CLK(CLK), .RST(RST), .in_data(inData), .in_valid(inValid), .in_ready(inReady[0]),
        .ser_en(serEn), .ser_data(serData[0]), .ser_busy(serBusy[0]), .ser_done(serDone[0])
    );
    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PAR_EN(0), .PAR_ODD(0)) dutMsb (
        .CLK(CLK), .RST(RST), .in_data(inData), .in_valid(inValid), .in_ready(inReady[1]),
        .ser_en(serEn), .ser_data(serData[1]), .ser_busy(serBusy[1]), .ser_done(serDone[1])
    );
    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_EN(1), .PAR_ODD(0)) dutEven (
        .CLK(CLK), .RST(RST), .in_data(inData), .in_valid(inValid), .in_ready(inReady[2]),
        .ser_en(serEn), .ser_data(serData[2]), .ser_busy(serBusy[2]), .ser_done(serDone[2])
    );
    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PAR_EN(1), .PAR_ODD(1)) dutOdd (
        .CLK(CLK), .RST(RST), .in_data(inData), .in_valid(inValid), .in_ready(inReady[3]),
        .ser_en(serEn), .ser_data(serData[3]), .ser_busy(serBusy[3]), .ser_done(serDone[3])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Sequences are given with bit k = k-th bit on the line (parity in bit 8 for the parity instances).
    task automatic applyStimulus(input logic [7:0] word, input logic [8:0] s0, input logic [8:0] s1,
                                 input logic [8:0] s2, input logic [8:0] s3,
                                 input int stallAt, input int stallLen);
        logic [8:0] seq[4];
        int         n[4] = '{8, 8, 9, 9};
        int         cnt[4];
        logic [3:0] fin;
        logic [3:0] expDone;
        logic       en;
        int         c;
        seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        fin = '0;
        expDone = '0;
        inData = word; inValid = 1'b1; serEn = 1'b1;
        checkOutput($sformatf("ready before %02h", word), {28'b0, inReady}, 32'hF);
        @(posedge CLK); #1;
        inValid = 1'b0;
        checkOutput($sformatf("hold full %02h", word), {28'b0, inReady}, 32'h0);
        checkOutput($sformatf("idle after accept %02h", word), {28'b0, serBusy}, 32'h0);
        @(posedge CLK); #1;
        checkOutput($sformatf("ready after load %02h", word), {28'b0, inReady}, 32'hF);
        checkOutput($sformatf("busy after load %02h", word), {28'b0, serBusy}, 32'hF);
        c = 0;
        while (fin != 4'hF && c < 30) begin
            en = !(stallAt >= 0 && c > stallAt && c <= stallAt + stallLen);
            serEn = en;
            @(posedge CLK); #1;
            for (int d = 0; d < 4; d++) begin
                if (expDone[d]) begin
                    fin[d] = 1'b1;
                    expDone[d] = 1'b0;
                end else if (!fin[d] && en && cnt[d] < n[d]) begin
                    cnt[d]++;
                    expDone[d] = (cnt[d] == n[d]);
                end
                if (cnt[d] > 0)
                    checkOutput($sformatf("d%0d data %02h c%0d", d, word, c), {31'b0, serData[d]},
                                {31'b0, seq[d][cnt[d]-1]});
                checkOutput($sformatf("d%0d done %02h c%0d", d, word, c), {31'b0, serDone[d]}, {31'b0, expDone[d]});
                checkOutput($sformatf("d%0d busy %02h c%0d", d, word, c), {31'b0, serBusy[d]}, {31'b0, !fin[d]});
            end
            c++;
        end
        checkOutput($sformatf("drain in time %02h", word), {31'b0, fin == 4'hF}, 32'h1);
        serEn = 1'b1;
    endtask

    task automatic applyBackToBack();
        logic [18:0] bbData  = 19'h6A855;
        logic [18:0] bbDone  = 19'h20080;
        logic [18:0] bbBusy  = 19'h3FEFF;
        logic [18:0] bbReady = 19'h7FE00;
        int          w;
        inData = 8'h55; inValid = 1'b1; serEn = 1'b1;
        @(posedge CLK); #1;
        inData = 8'hAA;
        @(posedge CLK); #1;
        checkOutput("b2b ready after first load", {31'b0, inReady[0]}, 32'h1);
        for (int i = 0; i < 19; i++) begin
            @(posedge CLK); #1;
            if (i == 0) inValid = 1'b0;
            checkOutput($sformatf("b2b data i%0d", i), {31'b0, serData[0]}, {31'b0, bbData[i]});
            checkOutput($sformatf("b2b done i%0d", i), {31'b0, serDone[0]}, {31'b0, bbDone[i]});
            checkOutput($sformatf("b2b busy i%0d", i), {31'b0, serBusy[0]}, {31'b0, bbBusy[i]});
            checkOutput($sformatf("b2b ready i%0d", i), {31'b0, inReady[0]}, {31'b0, bbReady[i]});
        end
        w = 0;
        while ((serBusy != 4'h0 || inReady != 4'hF) && w < 12) begin
            @(posedge CLK); #1;
            w++;
        end
        checkOutput("b2b all idle", {27'b0, serBusy, inReady}, {27'b0, 4'h0, 4'hF});
    endtask

    task automatic applyResetMidWord();
        inData = 8'hB1; inValid = 1'b1; serEn = 1'b1;
        @(posedge CLK); #1;
        inData = 8'h0E;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        inValid = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        checkOutput("mid-word 5th bit", {31'b0, serData[0]}, 32'h1);
        checkOutput("mid-word hold full", {28'b0, inReady}, 32'h0);
        #2 RST = 1'b0;
        #1;
        checkOutput("async rst data", {28'b0, serData}, 32'h0);
        checkOutput("async rst busy", {28'b0, serBusy}, 32'h0);
        checkOutput("async rst done", {28'b0, serDone}, 32'h0);
        checkOutput("async rst ready", {28'b0, inReady}, 32'hF);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            checkOutput($sformatf("post rst quiet %0d", i), {20'b0, serData, serBusy, serDone},
                        32'h0);
            checkOutput($sformatf("post rst ready %0d", i), {28'b0, inReady}, 32'hF);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b0; inData = 8'h00; inValid = 1'b0; serEn = 1'b0;
        #1;
        checkOutput("reset data", {28'b0, serData}, 32'h0);
        checkOutput("reset busy", {28'b0, serBusy}, 32'h0);
        checkOutput("reset done", {28'b0, serDone}, 32'h0);
        checkOutput("reset ready", {28'b0, inReady}, 32'hF);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        applyStimulus(8'hB1, 9'h0B1, 9'h08D, 9'h0B1, 9'h1B1, -1, 0);
        applyStimulus(8'h0E, 9'h00E, 9'h070, 9'h10E, 9'h00E, -1, 0);
        applyStimulus(8'hB1, 9'h0B1, 9'h08D, 9'h0B1, 9'h1B1, 3, 3);
        applyBackToBack();
        applyResetMidWord();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
